// File: rtl/xosera_pkg.sv
// Shared sprite geometry, fetch FSM state type and BRAM address packing
// for the sprite line renderer.
package xosera_pkg;

    localparam int SPRITE_W             = 32;
    localparam int SPRITE_H             = 32;
    localparam int SPRITE_WORDS_PER_ROW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] pack_addr(input logic [4:0] row, input logic [2:0] word);
        return {row, word};
    endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// Double-buffered 8x16 sprite row store: back filled by the fetcher, front
// read by the display path; swap copies back to front at line start.
module sprite_line_buf
    import xosera_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        swap,
    input  logic        wr_en,
    input  logic [2:0]  wr_word,
    input  logic [15:0] wr_data,
    input  logic        back_done,
    input  logic [4:0]  rd_col,
    output logic [3:0]  rd_nib,
    output logic        front_valid
);

    logic [15:0] back_r  [SPRITE_WORDS_PER_ROW];
    logic [15:0] front_r [SPRITE_WORDS_PER_ROW];
    logic        back_valid_r;
    logic        front_valid_r;
    logic [15:0] rd_word_s;

    // Buffer storage, swap and validity tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SPRITE_WORDS_PER_ROW; i++) begin
                back_r[i]  <= 16'h0000;
                front_r[i] <= 16'h0000;
            end
            back_valid_r  <= 1'b0;
            front_valid_r <= 1'b0;
        end else begin
            if (wr_en) begin
                back_r[wr_word] <= wr_data;
            end
            if (swap) begin
                for (int i = 0; i < SPRITE_WORDS_PER_ROW; i++) begin
                    front_r[i] <= back_r[i];
                end
                front_valid_r <= back_valid_r;
                back_valid_r  <= 1'b0;
            end else if (back_done) begin
                back_valid_r <= 1'b1;
            end
        end
    end

    // MSB-first nibble select: column 0 of a word is bits [15:12]
    always_comb begin
        rd_word_s = front_r[rd_col[4:2]];
        rd_nib    = 4'h0;
        case (rd_col[1:0])
            2'd0:    rd_nib = rd_word_s[15:12];
            2'd1:    rd_nib = rd_word_s[11:8];
            2'd2:    rd_nib = rd_word_s[7:4];
            2'd3:    rd_nib = rd_word_s[3:0];
            default: rd_nib = 4'h0;
        endcase
    end

    assign front_valid = front_valid_r;

endmodule

// File: rtl/sprite_line_render.sv
// Sprite line renderer: fetches the next scanline's sprite row from BRAM and
// displays the current one. Define SPRITE_HFLIP_EN to add the hflip_i input.
module sprite_line_render
    import xosera_pkg::*;
#(
    parameter int         COORD_W         = 11,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               line_start_i,
    input  logic [COORD_W-1:0] v_count_i,
    input  logic [COORD_W-1:0] h_count_i,
    input  logic [COORD_W-1:0] sprite_x_i,
    input  logic [COORD_W-1:0] sprite_y_i,
    input  logic               sprite_en_i,
`ifdef SPRITE_HFLIP_EN
    input  logic               hflip_i,
`endif
    output logic               rd_en_o,
    output logic [7:0]         rd_address_o,
    input  logic [15:0]        rd_data_i,
    output logic [3:0]         pixel_o,
    output logic               visible_o
);

    localparam logic [COORD_W-1:0] SPR_W_C   = COORD_W'(SPRITE_W);
    localparam logic [COORD_W-1:0] SPR_H_C   = COORD_W'(SPRITE_H);
    localparam logic [2:0]         LAST_WORD = 3'(SPRITE_WORDS_PER_ROW - 1);

    fetch_state_t       state_r, state_s;
    logic [2:0]         word_r, word_s;
    logic [4:0]         row_r, row_s;
    logic               rd_en_r, rd_en_s;
    logic [7:0]         rd_addr_r, rd_addr_s;
    logic               cap_en_r;
    logic [2:0]         cap_word_r;
    logic               back_done_s;
    logic [COORD_W-1:0] shadow_x_r;
    logic [COORD_W-1:0] line_row_s;
    logic               fetch_hit_s;
    logic [COORD_W-1:0] col_s;
    logic [4:0]         col_idx_s;
    logic               in_s;
    logic [3:0]         nib_s;
    logic               front_valid_s;
    logic [3:0]         pixel_r;
    logic               visible_r;
`ifdef SPRITE_HFLIP_EN
    logic               hflip_r;
`endif

    // Row within the sprite of the line after the one now starting (wraps mod 2^COORD_W)
    assign line_row_s  = v_count_i + COORD_W'(1) - sprite_y_i;
    assign fetch_hit_s = sprite_en_i && (line_row_s < SPR_H_C);

    // Fetch FSM next state; a line start always wins and restarts or cancels the fetch
    always_comb begin
        state_s     = state_r;
        word_s      = word_r;
        row_s       = row_r;
        rd_en_s     = 1'b0;
        rd_addr_s   = rd_addr_r;
        back_done_s = 1'b0;
        if (line_start_i) begin
            if (fetch_hit_s) begin
                state_s   = FETCH;
                word_s    = 3'd0;
                row_s     = line_row_s[4:0];
                rd_en_s   = 1'b1;
                rd_addr_s = pack_addr(line_row_s[4:0], 3'd0);
            end else begin
                state_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                FETCH: begin
                    if (word_r == LAST_WORD) begin
                        state_s = DRAIN;
                    end else begin
                        word_s    = word_r + 3'd1;
                        rd_en_s   = 1'b1;
                        rd_addr_s = pack_addr(row_r, word_s);
                    end
                end
                DRAIN: begin
                    state_s     = IDLE;
                    back_done_s = 1'b1;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Fetch state, read port registers and one-cycle-delayed capture tag
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            word_r     <= 3'd0;
            row_r      <= 5'd0;
            rd_en_r    <= 1'b0;
            rd_addr_r  <= 8'h00;
            cap_en_r   <= 1'b0;
            cap_word_r <= 3'd0;
        end else begin
            state_r    <= state_s;
            word_r     <= word_s;
            row_r      <= row_s;
            rd_en_r    <= rd_en_s;
            rd_addr_r  <= rd_addr_s;
            cap_en_r   <= rd_en_r && !line_start_i;
            cap_word_r <= rd_addr_r[2:0];
        end
    end

    // Per-line shadow copies of display controls
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_x_r <= '0;
`ifdef SPRITE_HFLIP_EN
            hflip_r    <= 1'b0;
`endif
        end else if (line_start_i) begin
            shadow_x_r <= sprite_x_i;
`ifdef SPRITE_HFLIP_EN
            hflip_r    <= hflip_i;
`endif
        end
    end

    sprite_line_buf u_buf (
        .clk         (clk),
        .reset_n     (reset_n_i),
        .swap        (line_start_i),
        .wr_en       (cap_en_r),
        .wr_word     (cap_word_r),
        .wr_data     (rd_data_i),
        .back_done   (back_done_s),
        .rd_col      (col_idx_s),
        .rd_nib      (nib_s),
        .front_valid (front_valid_s)
    );

    assign col_s = h_count_i - shadow_x_r;
    assign in_s  = front_valid_s && (col_s < SPR_W_C);

    // Column within the sprite, mirrored when flipped
    always_comb begin
        col_idx_s = col_s[4:0];
`ifdef SPRITE_HFLIP_EN
        if (hflip_r) begin
            col_idx_s = 5'd31 - col_s[4:0];
        end else begin
            col_idx_s = col_s[4:0];
        end
`endif
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pixel_r   <= 4'h0;
            visible_r <= 1'b0;
        end else begin
            pixel_r   <= in_s ? nib_s : 4'h0;
            visible_r <= in_s && (nib_s != TRANSPARENT_IDX);
        end
    end

    assign rd_en_o      = rd_en_r;
    assign rd_address_o = rd_addr_r;
    assign pixel_o      = pixel_r;
    assign visible_o    = visible_r;

endmodule
